// File: rtl/qspi_mem_pkg.sv
// Shared types, command opcodes and byte-enable helpers for the QPI memory controller.
package qspi_mem_pkg;

   typedef enum logic [3:0] {
      IDLE, WREN_CMD, WREN_GAP, CMD, ADDR, DUMMY, DATA, DONE, CS_HOLD, ERR
   } state_t;

   localparam logic [7:0] CMD_READ  = 8'hEB;
   localparam logic [7:0] CMD_WRITE = 8'h32;
   localparam logic [7:0] CMD_WREN  = 8'h06;

   // Only a single run of adjacent enabled bytes maps onto one flash burst.
   function automatic logic be_contiguous(input logic [3:0] be);
      case (be)
         4'b0001, 4'b0010, 4'b0100, 4'b1000,
         4'b0011, 4'b0110, 4'b1100,
         4'b0111, 4'b1110, 4'b1111: return 1'b1;
         default:                   return 1'b0;
      endcase
   endfunction

   function automatic logic [2:0] be_popcount(input logic [3:0] be);
      return 3'(be[0]) + 3'(be[1]) + 3'(be[2]) + 3'(be[3]);
   endfunction

   function automatic logic [1:0] be_lowest(input logic [3:0] be);
      if (be[0])      return 2'd0;
      else if (be[1]) return 2'd1;
      else if (be[2]) return 2'd2;
      else            return 2'd3;
   endfunction

endpackage

// File: rtl/qspi_mem_ctrl_sck_gen.sv
// Mode-0 SCK generator: low half then high half, each CLK_DIV clk cycles, running only while enabled.
module qspi_sck_gen #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic ck,
   output logic fall_stb,
   output logic rise_stb
);

   localparam int CW = (2 * CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;

   logic [CW-1:0] cnt_reg;
   logic [CW-1:0] cnt_next;

   assign cnt_next = (cnt_reg == CW'(2 * CLK_DIV - 1)) ? '0 : cnt_reg + CW'(1);

   // rise_stb marks the first high cycle, fall_stb the last cycle of the period.
   assign rise_stb = en && (cnt_reg == CW'(CLK_DIV));
   assign fall_stb = en && (cnt_reg == CW'(2 * CLK_DIV - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_reg <= '0;
         ck      <= 1'b0;
      end else if (!en) begin
         cnt_reg <= '0;
         ck      <= 1'b0;
      end else begin
         cnt_reg <= cnt_next;
         ck      <= (cnt_next >= CW'(CLK_DIV));
      end
   end

endmodule

// File: rtl/qspi_mem_ctrl.sv
// QPI flash/SRAM master turning single-word requests into quad-SPI transactions.
// Define QSPI_MEM_WREN_EN to precede every valid write with a WREN (0x06) transaction.
module qspi_mem_ctrl
   import qspi_mem_pkg::*;
#(
   parameter int CLK_DIV   = 2,
   parameter int ADDR_W    = 24,
   parameter int DUMMY_CYC = 6,
   parameter int CS_IDLE   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_i,
   output logic        ready_o,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] wdata_i,
   output logic        rvalid_o,
   output logic        err_o,
   output logic [31:0] rdata_o,
   input  logic [3:0]  qspi_io_i,
   output logic [3:0]  qspi_io_o,
   output logic [3:0]  qspi_io_t,
   output logic        qspi_ck_o,
   output logic        qspi_cs_o
);

   localparam int ANIB = ADDR_W / 4;

   state_t            state_reg;
   logic              we_reg;
   logic [ADDR_W-1:0] addr_sr_reg;
   logic [31:0]       wdata_reg;
   logic [3:0]        nwr_reg;
   logic [7:0]        idx_reg;
   logic [7:0]        cmd_reg;
   logic [31:0]       rbuf_reg;
   logic [31:0]       rbuf_next;

   logic       sck_en;
   logic       fall_stb;
   logic       rise_stb;
   logic [1:0] be_lo;
   logic [2:0] be_pop;
   logic       last_data;
   logic       unused;

   assign unused = ^{addr_i[31:ADDR_W], addr_i[1:0]};

   assign be_lo  = be_lowest(be_i);
   assign be_pop = be_popcount(be_i);
   assign sck_en = state_reg inside {WREN_CMD, CMD, ADDR, DUMMY, DATA};

   assign last_data = we_reg ? (idx_reg == ({4'd0, nwr_reg} - 8'd1)) : (idx_reg == 8'd7);

   // Nibble j of a little-endian word: byte j/2, high nibble on even j.
   function automatic logic [3:0] data_nib(input logic [31:0] w, input logic [7:0] j);
      return w[{j[2:1], ~j[0], 2'b00} +: 4];
   endfunction

   always_comb begin
      rbuf_next = rbuf_reg;
      if (state_reg == DATA && !we_reg && rise_stb)
         rbuf_next[{idx_reg[2:1], ~idx_reg[0], 2'b00} +: 4] = qspi_io_i;
   end

   qspi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
      .clk      (clk),
      .rst      (rst),
      .en       (sck_en),
      .ck       (qspi_ck_o),
      .fall_stb (fall_stb),
      .rise_stb (rise_stb)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg   <= IDLE;
         ready_o     <= 1'b1;
         rvalid_o    <= 1'b0;
         err_o       <= 1'b0;
         rdata_o     <= '0;
         qspi_cs_o   <= 1'b1;
         qspi_io_o   <= 4'h0;
         qspi_io_t   <= 4'hF;
         we_reg      <= 1'b0;
         addr_sr_reg <= '0;
         wdata_reg   <= '0;
         nwr_reg     <= '0;
         idx_reg     <= '0;
         cmd_reg     <= '0;
         rbuf_reg    <= '0;
      end else begin
         rvalid_o <= 1'b0;
         err_o    <= 1'b0;
         rbuf_reg <= rbuf_next;
         case (state_reg)
            IDLE: begin
               if (req_i) begin
                  we_reg  <= we_i;
                  idx_reg <= '0;
                  ready_o <= 1'b0;
                  if (we_i && !be_contiguous(be_i)) begin
                     state_reg <= ERR;
                     rvalid_o  <= 1'b1;
                     err_o     <= 1'b1;
                  end else begin
                     qspi_cs_o   <= 1'b0;
                     qspi_io_t   <= 4'h0;
                     addr_sr_reg <= {addr_i[ADDR_W-1:2], (we_i ? be_lo : 2'b00)};
                     wdata_reg   <= wdata_i >> {be_lo, 3'b000};
                     nwr_reg     <= {be_pop, 1'b0};
                     cmd_reg     <= we_i ? CMD_WRITE : CMD_READ;
`ifdef QSPI_MEM_WREN_EN
                     if (we_i) begin
                        state_reg <= WREN_CMD;
                        qspi_io_o <= CMD_WREN[7:4];
                     end else begin
                        state_reg <= CMD;
                        qspi_io_o <= CMD_READ[7:4];
                     end
`else
                     state_reg <= CMD;
                     qspi_io_o <= we_i ? CMD_WRITE[7:4] : CMD_READ[7:4];
`endif
                  end
               end
            end
            WREN_CMD: begin
               if (fall_stb) begin
                  if (idx_reg == 8'd0) begin
                     qspi_io_o <= CMD_WREN[3:0];
                     idx_reg   <= 8'd1;
                  end else begin
                     state_reg <= WREN_GAP;
                     qspi_cs_o <= 1'b1;
                     qspi_io_t <= 4'hF;
                     qspi_io_o <= 4'h0;
                     idx_reg   <= '0;
                  end
               end
            end
            WREN_GAP: begin
               // cs stays high CS_IDLE+1 cycles before the write re-opens it.
               if (idx_reg == 8'(CS_IDLE)) begin
                  state_reg <= CMD;
                  qspi_cs_o <= 1'b0;
                  qspi_io_t <= 4'h0;
                  qspi_io_o <= cmd_reg[7:4];
                  idx_reg   <= '0;
               end else begin
                  idx_reg <= idx_reg + 8'd1;
               end
            end
            CMD: begin
               if (fall_stb) begin
                  if (idx_reg == 8'd0) begin
                     qspi_io_o <= cmd_reg[3:0];
                     idx_reg   <= 8'd1;
                  end else begin
                     state_reg   <= ADDR;
                     idx_reg     <= '0;
                     qspi_io_o   <= addr_sr_reg[ADDR_W-1 -: 4];
                     addr_sr_reg <= {addr_sr_reg[ADDR_W-5:0], 4'h0};
                  end
               end
            end
            ADDR: begin
               if (fall_stb) begin
                  if (idx_reg == 8'(ANIB - 1)) begin
                     idx_reg <= '0;
                     if (we_reg) begin
                        state_reg <= DATA;
                        qspi_io_o <= data_nib(wdata_reg, 8'd0);
                     end else begin
                        state_reg <= DUMMY;
                        qspi_io_t <= 4'hF;
                        qspi_io_o <= 4'h0;
                     end
                  end else begin
                     idx_reg     <= idx_reg + 8'd1;
                     qspi_io_o   <= addr_sr_reg[ADDR_W-1 -: 4];
                     addr_sr_reg <= {addr_sr_reg[ADDR_W-5:0], 4'h0};
                  end
               end
            end
            DUMMY: begin
               if (fall_stb) begin
                  if (idx_reg == 8'(DUMMY_CYC - 1)) begin
                     state_reg <= DATA;
                     idx_reg   <= '0;
                  end else begin
                     idx_reg <= idx_reg + 8'd1;
                  end
               end
            end
            DATA: begin
               if (fall_stb) begin
                  if (last_data) begin
                     state_reg <= DONE;
                     qspi_cs_o <= 1'b1;
                     qspi_io_t <= 4'hF;
                     qspi_io_o <= 4'h0;
                     rvalid_o  <= 1'b1;
                     idx_reg   <= '0;
                     if (!we_reg) rdata_o <= rbuf_next;
                  end else begin
                     idx_reg <= idx_reg + 8'd1;
                     if (we_reg) qspi_io_o <= data_nib(wdata_reg, idx_reg + 8'd1);
                  end
               end
            end
            DONE: begin
               if (CS_IDLE <= 1) begin
                  state_reg <= IDLE;
                  ready_o   <= 1'b1;
               end else begin
                  state_reg <= CS_HOLD;
               end
            end
            CS_HOLD: begin
               if (idx_reg == 8'(CS_IDLE - 2)) begin
                  state_reg <= IDLE;
                  ready_o   <= 1'b1;
               end else begin
                  idx_reg <= idx_reg + 8'd1;
               end
            end
            ERR: begin
               state_reg <= IDLE;
               ready_o   <= 1'b1;
            end
            default: begin
               state_reg <= IDLE;
               ready_o   <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_qspi_mem_ctrl.sv
// Directed bench for qspi_mem_ctrl with a QPI flash model and an expectation queue.
module tb_qspi_mem_ctrl;

   localparam int CLK_DIV   = 2;
   localparam int ADDR_W    = 24;
   localparam int DUMMY_CYC = 6;
   localparam int CS_IDLE   = 2;
   localparam int ANIB      = ADDR_W / 4;
   localparam int PER       = 2 * CLK_DIV;
   localparam int RD_LAT    = 1 + (2 + ANIB + DUMMY_CYC + 8) * PER;
   localparam int RD_START  = 2 + ANIB + DUMMY_CYC;
`ifdef QSPI_MEM_WREN_EN
   localparam int WREN_ADD  = 1 + 4 * CLK_DIV + CS_IDLE;
`else
   localparam int WREN_ADD  = 0;
`endif

   typedef struct {
      logic        we;
      logic [31:0] rdata;
      logic        err;
      int          lat;
      logic [63:0] nib;
      int          nn;
   } exp_t;

   exp_t sb[$];

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_i = 1'b0;
   logic        ready_o;
   logic        we_i = 1'b0;
   logic [31:0] addr_i = '0;
   logic [3:0]  be_i = '0;
   logic [31:0] wdata_i = '0;
   logic        rvalid_o;
   logic        err_o;
   logic [31:0] rdata_o;
   logic [3:0]  qspi_io_i = 4'h0;
   logic [3:0]  qspi_io_o;
   logic [3:0]  qspi_io_t;
   logic        qspi_ck_o;
   logic        qspi_cs_o;

   int cyc = 0;
   int n_checks = 0;
   int n_fail = 0;

   qspi_mem_ctrl #(
      .CLK_DIV(CLK_DIV), .ADDR_W(ADDR_W), .DUMMY_CYC(DUMMY_CYC), .CS_IDLE(CS_IDLE)
   ) dut (
      .clk(clk), .rst(rst), .req_i(req_i), .ready_o(ready_o), .we_i(we_i),
      .addr_i(addr_i), .be_i(be_i), .wdata_i(wdata_i), .rvalid_o(rvalid_o),
      .err_o(err_o), .rdata_o(rdata_o), .qspi_io_i(qspi_io_i), .qspi_io_o(qspi_io_o),
      .qspi_io_t(qspi_io_t), .qspi_ck_o(qspi_ck_o), .qspi_cs_o(qspi_cs_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Flash model: captures driven nibbles on each SCK rise, returns read bytes 11,22,33,44.
   logic        prev_ck = 1'b0;
   logic        prev_cs = 1'b1;
   logic [63:0] cap = '0;
   int          ncap = 0;
   int          rises = 0;
   int          jn;
   logic [31:0] flash_word = 32'h44332211;

   always @(negedge clk) begin
      prev_ck <= qspi_ck_o;
      prev_cs <= qspi_cs_o;
      if (qspi_cs_o) begin
         qspi_io_i <= 4'h0;
      end else if (prev_cs) begin
         cap   <= '0;
         ncap  <= 0;
         rises <= 0;
      end else if (qspi_ck_o && !prev_ck) begin
         rises <= rises + 1;
         if (qspi_io_t == 4'h0) begin
            cap  <= {cap[59:0], qspi_io_o};
            ncap <= ncap + 1;
         end
      end else if (!qspi_ck_o && prev_ck && qspi_io_t == 4'hF &&
                   rises >= RD_START && rises < RD_START + 8) begin
         jn = rises - RD_START;
         qspi_io_i <= flash_word[8 * (jn / 2) + ((jn % 2 == 0) ? 4 : 0) +: 4];
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t mk(input logic we, input logic [31:0] rd, input logic err,
                               input int lat, input logic [63:0] nib, input int nn);
      exp_t e;
      e.we = we; e.rdata = rd; e.err = err; e.lat = lat; e.nib = nib; e.nn = nn;
      return e;
   endfunction

   // Called at a negedge; leaves req_i high and returns the acceptance cycle T0.
   task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, output int t0);
      req_i = 1'b1; we_i = we; addr_i = addr; be_i = be; wdata_i = wd;
      t0 = -1;
      for (int i = 0; i < 400; i++) begin
         if (ready_o) begin
            t0 = cyc;
            break;
         end
         @(negedge clk);
      end
      check("accept_ready", ready_o, 1'b1);
   endtask

   task automatic wait_rv(input logic hold, output int t);
      t = -1;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (!hold) req_i = 1'b0;
         if (rvalid_o) begin
            t = cyc;
            break;
         end
      end
      check("rvalid_seen", rvalid_o, 1'b1);
   endtask

   task automatic score(input int t0, input int trv);
      exp_t e;
      e = sb.pop_front();
      check("latency", 64'(trv - t0), 64'(e.lat));
      check("err", err_o, e.err);
      if (!e.we) check("rdata", rdata_o, e.rdata);
      if (!e.err) begin
         check("nibbles", cap, e.nib);
         check("nibble_count", 64'(ncap), 64'(e.nn));
      end
      $display("txn we=%0d latency=%0d err=%0d rdata=%08h nibbles=%0h", e.we, trv - t0, err_o, rdata_o, cap);
   endtask

   int t0, trv, rv1, rv2, t0b;

   initial begin
      repeat (2) @(negedge clk);
      check("rst_ready", ready_o, 1'b1);
      check("rst_cs", qspi_cs_o, 1'b1);
      check("rst_io_t", qspi_io_t, 4'hF);
      check("rst_rvalid", rvalid_o, 1'b0);
      rst = 1'b1;
      @(negedge clk);

      // 1: read 0x104
      issue(1'b0, 32'h104, 4'hF, 32'h0, t0);
      sb.push_back(mk(1'b0, 32'h44332211, 1'b0, RD_LAT, 64'hEB000104, 8));
      wait_rv(1'b0, trv);
      score(t0, trv);

      // 2: full-word write
      issue(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, t0);
      sb.push_back(mk(1'b1, 32'h0, 1'b0, 1 + (2 + ANIB + 8) * PER + WREN_ADD,
                      64'h32000010_EFBEADDE, 16));
      wait_rv(1'b0, trv);
      score(t0, trv);
      check("rdata_held", rdata_o, 32'h44332211);

      // 3: upper half-word write
      issue(1'b1, 32'h20, 4'b1100, 32'hAABBCCDD, t0);
      sb.push_back(mk(1'b1, 32'h0, 1'b0, 1 + (2 + ANIB + 4) * PER + WREN_ADD,
                      64'h3200_0022_BBAA, 12));
      wait_rv(1'b0, trv);
      score(t0, trv);

      // 4: non-contiguous byte enables
      issue(1'b1, 32'h40, 4'b0101, 32'h12345678, t0);
      sb.push_back(mk(1'b1, 32'h0, 1'b1, 1, 64'h0, 0));
      wait_rv(1'b0, trv);
      score(t0, trv);
      check("err_cs_high", qspi_cs_o, 1'b1);
      check("err_ready_low", ready_o, 1'b0);
      @(negedge clk);
      check("err_ready_back", ready_o, 1'b1);
      check("err_rvalid_drop", rvalid_o, 1'b0);

      // 5: reset during the address phase
      issue(1'b0, 32'h104, 4'hF, 32'h0, t0);
      sb.push_back(mk(1'b0, 32'h44332211, 1'b0, RD_LAT, 64'hEB000104, 8));
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         req_i = 1'b0;
      end
      check("mid_addr_cs_low", qspi_cs_o, 1'b0);
      #1 rst = 1'b0;
      #1;
      check("arst_ready", ready_o, 1'b1);
      check("arst_cs", qspi_cs_o, 1'b1);
      check("arst_ck", qspi_ck_o, 1'b0);
      check("arst_io_t", qspi_io_t, 4'hF);
      check("arst_io_o", qspi_io_o, 4'h0);
      check("arst_rdata", rdata_o, 32'h0);
      check("arst_rvalid_err", {rvalid_o, err_o}, 2'b00);
      void'(sb.pop_front());
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      issue(1'b0, 32'h104, 4'hF, 32'h0, t0);
      sb.push_back(mk(1'b0, 32'h44332211, 1'b0, RD_LAT, 64'hEB000104, 8));
      wait_rv(1'b0, trv);
      score(t0, trv);

      // 6: back-to-back reads with req_i held high
      issue(1'b0, 32'h104, 4'hF, 32'h0, t0);
      sb.push_back(mk(1'b0, 32'h44332211, 1'b0, RD_LAT, 64'hEB000104, 8));
      wait_rv(1'b1, rv1);
      score(t0, rv1);
      check("gap_cs_done", qspi_cs_o, 1'b1);
      @(negedge clk);
      check("gap_cs_hold", qspi_cs_o, 1'b1);
      check("gap_ready_low", ready_o, 1'b0);
      @(negedge clk);
      check("gap_ready_high", ready_o, 1'b1);
      t0b = cyc;
      sb.push_back(mk(1'b0, 32'h44332211, 1'b0, RD_LAT, 64'hEB000104, 8));
      @(negedge clk);
      check("gap_cs_fall", qspi_cs_o, 1'b0);
      req_i = 1'b0;
      wait_rv(1'b0, rv2);
      score(t0b, rv2);
      check("rvalid_spacing", 64'(rv2 - rv1), 64'(RD_LAT + CS_IDLE));

      repeat (4) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
